// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer control master: timer register map,
// control register bit positions, command opcodes, FSM states and the
// bus-cycle record with small constructors for idle, write and read cycles.
package timer_ctrl_pkg;

  // Timer slave word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Command opcodes; 5..7 are reserved
  localparam logic [2:0] OP_PROGRAM  = 3'd0;
  localparam logic [2:0] OP_STOP     = 3'd1;
  localparam logic [2:0] OP_SNAPSHOT = 3'd2;
  localparam logic [2:0] OP_STATUS   = 3'd3;
  localparam logic [2:0] OP_ACK      = 3'd4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    P_STOP   = 4'd1,
    P_PL     = 4'd2,
    P_PH     = 4'd3,
    P_CTRL   = 4'd4,
    STOP_WR  = 4'd5,
    SN_WR    = 4'd6,
    SN_RL    = 4'd7,
    SN_RH    = 4'd8,
    SN_CAP   = 4'd9,
    ST_RD    = 4'd10,
    ST_CAP   = 4'd11,
    ACK_WR   = 4'd12,
    ACK_WAIT = 4'd13,
    DONE     = 4'd14
  } state_e;

  // One bus cycle as driven towards the timer slave
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  function automatic bus_t bus_idle();
    bus_t b;
    b.cs      = 1'b0;
    b.write_n = 1'b1;
    b.addr    = 3'd0;
    b.wdata   = 16'h0000;
    return b;
  endfunction

  function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b0;
    b.addr    = addr;
    b.wdata   = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [2:0] addr);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b1;
    b.addr    = addr;
    b.wdata   = 16'h0000;
    return b;
  endfunction

  // Control word that halts the timer
  function automatic logic [15:0] stop_word();
    logic [15:0] w;
    w            = 16'h0000;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

  // Control word that starts the timer with the given mode bits
  function automatic logic [15:0] start_word(input logic cont, input logic ien);
    logic [15:0] w;
    w             = 16'h0000;
    w[CTRL_START] = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ien;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master_if.sv
// Command/response handshake plus the Avalon-style bus towards the timer
// slave and its interrupt line. The master modport is the controller's view.
interface timer_ctrl_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        cmd_irq_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        irq;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    input  irq, avm_readdata,
    output cmd_ready, rsp_valid, rsp_data,
    output avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    output irq, avm_readdata,
    input  cmd_ready, rsp_valid, rsp_data,
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Timer control master: turns PROGRAM/STOP/SNAPSHOT/STATUS/ACK commands into
// register-level bus sequences on a 16-bit timer slave and reports completion.
// Optional feature macro: TIMER_CTRL_MASTER_AUTO_ACK_EN -- when defined, a
// level irq seen in IDLE is acknowledged automatically (ahead of any waiting
// command) and counted in tick_count; otherwise irq is ignored and
// tick_count stays 0.
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_ctrl_master_if.master  bus,
  output logic [TICK_W-1:0]    tick_count
);

  state_e      state_r;
  bus_t        bus_r;
  logic        ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;
  logic [31:0] period_r;
  logic        cont_r;
  logic        ien_r;
  logic        auto_r;
  logic [15:0] snap_lo_r;
  logic        auto_req_s;
  logic        accept_s;

`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
  logic [TICK_W-1:0] tick_r;
  assign auto_req_s = bus.irq;
  assign tick_count = tick_r;
`else
  logic unused_irq;
  assign unused_irq = bus.irq;
  assign auto_req_s = 1'b0;
  assign tick_count = {TICK_W{1'b0}};
`endif

  // A pending interrupt holds off new commands so the auto-ack wins a tie
  assign bus.cmd_ready      = ready_r & ~auto_req_s;
  assign accept_s           = bus.cmd_valid & bus.cmd_ready;
  assign bus.rsp_valid      = rsp_valid_r;
  assign bus.rsp_data       = rsp_data_r;
  assign bus.avm_chipselect = bus_r.cs;
  assign bus.avm_write_n    = bus_r.write_n;
  assign bus.avm_address    = bus_r.addr;
  assign bus.avm_writedata  = bus_r.wdata;

  // Sequencer: each transition loads the bus cycle of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      bus_r       <= bus_idle();
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      period_r    <= 32'h0000_0000;
      cont_r      <= 1'b0;
      ien_r       <= 1'b0;
      auto_r      <= 1'b0;
      snap_lo_r   <= 16'h0000;
`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
      tick_r      <= {TICK_W{1'b0}};
`endif
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (auto_req_s) begin
            state_r <= ACK_WR;
            bus_r   <= bus_write(ADDR_STATUS, 16'h0000);
            ready_r <= 1'b0;
            auto_r  <= 1'b1;
`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
            tick_r  <= tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
`endif
          end else if (accept_s) begin
            period_r <= bus.cmd_period;
            cont_r   <= bus.cmd_continuous;
            ien_r    <= bus.cmd_irq_en;
            ready_r  <= 1'b0;
            auto_r   <= 1'b0;
            case (bus.cmd_op)
              OP_PROGRAM: begin
                state_r <= P_STOP;
                bus_r   <= bus_write(ADDR_CONTROL, stop_word());
              end
              OP_STOP: begin
                state_r <= STOP_WR;
                bus_r   <= bus_write(ADDR_CONTROL, stop_word());
              end
              OP_SNAPSHOT: begin
                state_r <= SN_WR;
                bus_r   <= bus_write(ADDR_SNAPL, 16'h0000);
              end
              OP_STATUS: begin
                state_r <= ST_RD;
                bus_r   <= bus_read(ADDR_STATUS);
              end
              OP_ACK: begin
                state_r <= ACK_WR;
                bus_r   <= bus_write(ADDR_STATUS, 16'h0000);
              end
              default: begin
                // Reserved opcode: complete immediately, no bus traffic
                state_r     <= DONE;
                bus_r       <= bus_idle();
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= 32'h0000_0000;
              end
            endcase
          end else begin
            bus_r <= bus_idle();
          end
        end
        P_STOP: begin
          state_r <= P_PL;
          bus_r   <= bus_write(ADDR_PERIODL, period_r[15:0]);
        end
        P_PL: begin
          state_r <= P_PH;
          bus_r   <= bus_write(ADDR_PERIODH, period_r[31:16]);
        end
        P_PH: begin
          state_r <= P_CTRL;
          bus_r   <= bus_write(ADDR_CONTROL, start_word(cont_r, ien_r));
        end
        P_CTRL, STOP_WR: begin
          state_r     <= DONE;
          bus_r       <= bus_idle();
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= 32'h0000_0000;
        end
        SN_WR: begin
          state_r <= SN_RL;
          bus_r   <= bus_read(ADDR_SNAPL);
        end
        SN_RL: begin
          state_r <= SN_RH;
          bus_r   <= bus_read(ADDR_SNAPH);
        end
        SN_RH: begin
          // Read data trails its address by one cycle: this is the low half
          state_r   <= SN_CAP;
          bus_r     <= bus_idle();
          snap_lo_r <= bus.avm_readdata;
        end
        SN_CAP: begin
          state_r     <= DONE;
          bus_r       <= bus_idle();
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= {bus.avm_readdata, snap_lo_r};
        end
        ST_RD: begin
          state_r <= ST_CAP;
          bus_r   <= bus_idle();
        end
        ST_CAP: begin
          state_r     <= DONE;
          bus_r       <= bus_idle();
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= {30'h0000_0000, bus.avm_readdata[1:0]};
        end
        ACK_WR: begin
          state_r <= ACK_WAIT;
          bus_r   <= bus_idle();
        end
        ACK_WAIT: begin
          // One settling cycle so the cleared irq is seen before IDLE decides
          bus_r <= bus_idle();
          if (auto_r) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            auto_r  <= 1'b0;
          end else begin
            state_r     <= DONE;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= 32'h0000_0000;
          end
        end
        DONE: begin
          state_r <= IDLE;
          bus_r   <= bus_idle();
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          bus_r   <= bus_idle();
          ready_r <= 1'b1;
          auto_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master. Expected bus cycles and responses,
// stamped with the cycle they must appear in, are derived from each
// command's documented register sequence and queued when the command is
// accepted; a monitor compares every cycle against the queues.
// With TIMER_CTRL_MASTER_AUTO_ACK_EN defined the auto-ack path is exercised
// and the DUT is built with an 8-bit tick counter so wrap-around is reached
// quickly.
module tb_timer_ctrl_master;

`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
  localparam int TW = 8;
`else
  localparam int TW = 16;
`endif

  typedef struct {
    int unsigned cyc;
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] data;
    bit          auto_ack;
  } bus_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } rsp_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] tick_count;
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          rst_seen = 1'b0;
  logic          irq_raise;
  logic          irq_drop;
  logic          irq_r = 1'b0;
  logic [15:0]   rdata_r = 16'h0000;
  logic [15:0]   rd_val [0:7];
  bus_exp_t      bus_q [$];
  rsp_exp_t      rsp_q [$];
  logic [31:0]   last_rsp = 32'h0;
  logic [TW-1:0] exp_tick = '0;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.TICK_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  // Cycle counter and record of whether the last edge applied reset
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // Timer slave model: registered read data one cycle after the address,
  // interrupt level cleared by a write to the status register
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write_n) rdata_r <= rd_val[bus.avm_address];
    else rdata_r <= 16'h0000;
    if (irq_raise) irq_r <= 1'b1;
    else if (irq_drop || (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0)) irq_r <= 1'b0;
  end

  assign bus.avm_readdata = rdata_r;
  assign bus.irq          = irq_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_bus(input int unsigned c, input bit wr, input logic [2:0] a,
                          input logic [15:0] d, input bit au);
    bus_exp_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.data = d; e.auto_ack = au;
    bus_q.push_back(e);
  endtask

  task automatic push_rsp(input int unsigned c, input logic [31:0] d);
    rsp_exp_t e;
    e.cyc = c; e.data = d;
    rsp_q.push_back(e);
  endtask

  // Reference: the register sequence each command must produce, from cycle a
  task automatic model_push(input logic [2:0] op, input logic [31:0] per,
                            input logic cont, input logic ien, input int unsigned a);
    case (op)
      3'd0: begin
        push_bus(a,     1'b1, 3'd1, 16'h0008, 1'b0);
        push_bus(a + 1, 1'b1, 3'd2, per[15:0], 1'b0);
        push_bus(a + 2, 1'b1, 3'd3, per[31:16], 1'b0);
        push_bus(a + 3, 1'b1, 3'd1, {13'h0000, 1'b1, cont, ien}, 1'b0);
        push_rsp(a + 4, 32'h0);
      end
      3'd1: begin
        push_bus(a, 1'b1, 3'd1, 16'h0008, 1'b0);
        push_rsp(a + 1, 32'h0);
      end
      3'd2: begin
        push_bus(a,     1'b1, 3'd4, 16'h0000, 1'b0);
        push_bus(a + 1, 1'b0, 3'd4, 16'h0000, 1'b0);
        push_bus(a + 2, 1'b0, 3'd5, 16'h0000, 1'b0);
        push_rsp(a + 4, {rd_val[5], rd_val[4]});
      end
      3'd3: begin
        push_bus(a, 1'b0, 3'd0, 16'h0000, 1'b0);
        push_rsp(a + 2, {30'h0, rd_val[0][1:0]});
      end
      3'd4: begin
        push_bus(a, 1'b1, 3'd0, 16'h0000, 1'b0);
        push_rsp(a + 2, 32'h0);
      end
      default: push_rsp(a, 32'h0);
    endcase
  endtask

  // Present a command, wait (bounded) for acceptance, optionally queue the model
  task automatic issue(input logic [2:0] op, input logic [31:0] per, input logic cont,
                       input logic ien, input bit push_en, output int unsigned acc);
    bit done;
    done               = 1'b0;
    bus.cmd_valid      = 1'b1;
    bus.cmd_op         = op;
    bus.cmd_period     = per;
    bus.cmd_continuous = cont;
    bus.cmd_irq_en     = ien;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    acc = cyc;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    else if (push_en) model_push(op, per, cont, ien, cyc);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60; t++) begin
      if (bus_q.size() == 0 && rsp_q.size() == 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic raise_irq();
    irq_raise = 1'b1;
`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
    push_bus(cyc + 2, 1'b1, 3'd0, 16'h0000, 1'b1);
`endif
    @(posedge clk); #1;
    irq_raise = 1'b0;
  endtask

  task automatic drop_irq();
    irq_drop = 1'b1;
    @(posedge clk); #1;
    irq_drop = 1'b0;
  endtask

  // Monitor: compare every cycle's bus, response and counter against the queues
  initial begin
    bus_exp_t be;
    rsp_exp_t re;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        last_rsp = 32'h0;
        exp_tick = '0;
        check("reset_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
      end
      while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
        be = bus_q.pop_front();
        check("bus_missing", 32'd0, be.cyc);
      end
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        re = rsp_q.pop_front();
        check("rsp_missing", 32'd0, re.cyc);
      end
      if (bus.avm_chipselect) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected", {29'h0, bus.avm_address}, 32'hFFFF_FFFF);
        end else begin
          be = bus_q.pop_front();
          check("bus_cycle", cyc, be.cyc);
          check("bus_addr", {29'h0, bus.avm_address}, {29'h0, be.addr});
          check("bus_write_n", {31'h0, bus.avm_write_n}, {31'h0, !be.wr});
          if (be.wr) check("bus_wdata", {16'h0, bus.avm_writedata}, {16'h0, be.data});
          if (be.auto_ack) exp_tick = exp_tick + 1'b1;
        end
      end else begin
        check("bus_idle", {12'h0, bus.avm_address, bus.avm_write_n, bus.avm_writedata},
              {12'h0, 3'd0, 1'b1, 16'h0000});
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_data, 32'hFFFF_FFFF);
        end else begin
          re = rsp_q.pop_front();
          check("rsp_cycle", cyc, re.cyc);
          check("rsp_data", bus.rsp_data, re.data);
          last_rsp = re.data;
        end
      end else begin
        check("rsp_hold", bus.rsp_data, last_rsp);
      end
      check("tick_count", 32'(tick_count), 32'(exp_tick));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    logic [2:0]  op;
    reset              = 1'b1;
    irq_raise          = 1'b0;
    irq_drop           = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_op         = 3'd0;
    bus.cmd_period     = 32'h0;
    bus.cmd_continuous = 1'b0;
    bus.cmd_irq_en     = 1'b0;
    for (int k = 0; k < 8; k++) rd_val[k] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed: PROGRAM with 100000 ticks, continuous, interrupt enabled
    issue(3'd0, 32'h0001_86A0, 1'b1, 1'b1, 1'b1, acc);
    wait_drain();
    // Directed: SNAPSHOT assembles high:low
    rd_val[4] = 16'h1234;
    rd_val[5] = 16'hABCD;
    issue(3'd2, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();
    // Directed: STATUS, then reserved op 6 which must zero rsp_data
    rd_val[0] = 16'h0003;
    issue(3'd3, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();
    issue(3'd6, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, acc);
    wait_drain();
    // Directed: STOP, commanded ACK, PROGRAM with a zero period
    issue(3'd1, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();
    issue(3'd4, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();
    issue(3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();

    // irq and a command arriving together
    raise_irq();
    issue(3'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, acc);
    wait_drain();
`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
    // Enough auto-acks to pass the counter's all-ones value
    for (int i = 0; i < 260; i++) begin
      raise_irq();
      wait_drain();
    end
`else
    drop_irq();
`endif

    // Randomized command mix against the reference sequences
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 8; k++) rd_val[k] = 16'($urandom);
`ifdef TIMER_CTRL_MASTER_AUTO_ACK_EN
      if ($urandom_range(0, 3) == 0) raise_irq();
`endif
      op = 3'($urandom_range(0, 7));
      issue(op, $urandom, 1'($urandom), 1'($urandom), 1'b1, acc);
      wait_drain();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Reset while the high period half is on the bus: no control write, no response
    issue(3'd0, 32'h0005_0007, 1'b1, 1'b0, 1'b0, acc);
    push_bus(acc,     1'b1, 3'd1, 16'h0008, 1'b0);
    push_bus(acc + 1, 1'b1, 3'd2, 16'h0007, 1'b0);
    push_bus(acc + 2, 1'b1, 3'd3, 16'h0005, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_reset", {31'h0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // A command after reset must run normally
    issue(3'd1, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    wait_drain();
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("queues_drained", bus_q.size() + rsp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_master.md
TIMER_CTRL_MASTER -- requirements
Module: timer_ctrl_master

Interface
REQ-001 Parameter TICK_W, default 16: width of the serviced-timeout counter.
REQ-002 clk  in  1  single clock; all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-006 cmd_op  in  3  0=PROGRAM, 1=STOP, 2=SNAPSHOT, 3=STATUS, 4=ACK; 5-7 reserved.
REQ-007 cmd_period  in  32  PROGRAM load value.
REQ-008 cmd_continuous  in  1  PROGRAM CONT bit.
REQ-009 cmd_irq_en  in  1  PROGRAM ITO bit.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_data  out  32  SNAPSHOT value, or STATUS in [1:0] ({RUN,TO}) with [31:2]=0; other ops give 0.
REQ-012 irq  in  1  timer interrupt, level.
REQ-013 avm_address  out  3  word address to the timer slave.
REQ-014 avm_chipselect  out  1  slave select.
REQ-015 avm_write_n  out  1  active-low write.
REQ-016 avm_writedata  out  16  write data.
REQ-017 avm_readdata  in  16  read data, valid exactly one cycle after the address is presented; no waitrequest.
REQ-018 tick_count  out  TICK_W  number of interrupts auto-acknowledged; wraps to 0 past all-ones.

Function
REQ-019 Bus idle (IDLE state and every non-bus state) SHALL be: chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 Each bus write SHALL occupy exactly one cycle: chipselect=1, write_n=0.
REQ-021 Each bus read SHALL present the address with chipselect=1 and write_n=1; the data is captured on the following edge.
REQ-022 States: IDLE, P_STOP, P_PL, P_PH, P_CTRL, STOP_WR, SN_WR, SN_RL, SN_RH, SN_CAP, ST_RD, ST_CAP, ACK_WR, ACK_WAIT, DONE.
REQ-023 cmd_ready=1 only in IDLE with no auto-ack pending.
REQ-024 Acceptance SHALL register the command fields. The first bus cycle SHALL follow on the very next cycle.
REQ-025 PROGRAM sequence, one write per cycle: addr1=0x0008 (stop), addr2=period[15:0], addr3=period[31:16], addr1={12'b0,0,1,cont,ien}.
REQ-026 PROGRAM latency: rsp_valid SHALL assert in cycle 5 after acceptance.
REQ-027 STOP: one write addr1=0x0008, then DONE.
REQ-028 SNAPSHOT sequence: write addr4=0; read addr4; read addr5 while capturing the low half; capture the high half in SN_CAP; then DONE.
REQ-029 STATUS: read addr0, capture [1:0], then DONE.
REQ-030 ACK (commanded): one write addr0=0, then ACK_WAIT, then DONE.
REQ-031 Reserved ops SHALL be accepted, produce no bus activity, and go straight to DONE with rsp_data=0.
REQ-032 DONE SHALL assert rsp_valid for one cycle and return to IDLE.
REQ-033 rsp_data SHALL hold its value until the next response.
REQ-034 Arbitration: if irq=1 in IDLE and cmd_valid=1 in the same cycle, the auto-ack (REQ-041) wins; the command waits.
REQ-035 ACK_WAIT SHALL last one cycle so the deasserted irq is seen before IDLE re-evaluates.
REQ-036 A PROGRAM with cmd_period=0 SHALL be written as-is, with no special casing.

Reset
REQ-037 reset SHALL force IDLE, bus idle, cmd_ready=1, rsp_valid=0, rsp_data=0, tick_count=0.
REQ-038 Reset mid-sequence SHALL abandon the sequence in the next cycle, with no further bus cycle and no response.

Configuration
REQ-039 Macro TIMER_CTRL_MASTER_AUTO_ACK_EN gates the auto-ack feature.
REQ-040 Without the macro: irq is ignored, tick_count is constant 0, and no auto-ack path exists.
REQ-041 With the macro: irq=1 in IDLE SHALL run ACK_WR -> ACK_WAIT -> IDLE with no rsp_valid, and tick_count SHALL increment once per auto-ack.

Structure
REQ-042 Package timer_ctrl_pkg SHALL hold: register address constants (0-5), control bit positions (ITO=0, CONT=1, START=2, STOP=3), cmd_op encodings and the state enum.
REQ-043 The block SHALL be a single module with no sub-module.

Verification
REQ-044 PROGRAM period=0x0001_86A0, cont=1, ien=1 -> writes (1,0x0008), (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles, and rsp_valid in cycle 5.
REQ-045 SNAPSHOT with the slave model returning 0x1234 then 0xABCD -> rsp_data=0xABCD1234, with a single write to addr4 first.
REQ-046 STATUS with the slave returning 0x0003 -> rsp_data=0x0000_0003; reserved op 6 -> rsp_data=0, no bus activity.
REQ-047 AUTO_ACK_EN: irq and cmd_valid rising together -> write (0,0x0000) first, tick_count 0->1, then the command proceeds; tick_count at 0xFFFF wraps to 0.
REQ-048 reset asserted during P_PH -> no P_CTRL write, no rsp_valid, cmd_ready=1 in the cycle after reset release.
